// File: rtl/alu_seq_if.sv
// Handshake and operand/result bus between the ALU sequencer and its environment
// (register file, ALU datapath, requester).
interface alu_seq_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] data_in;
  logic       opnd_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_opr;
  logic       alu_en;
  logic [7:0] alu_result;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       div_err;

  modport slave (
    input  start, op, data_in, alu_result,
    output opnd_sel, alu_a, alu_b, alu_opr, alu_en, busy, done, result,
           zero, carry, div_err
  );

  modport master (
    output start, op, data_in, alu_result,
    input  opnd_sel, alu_a, alu_b, alu_opr, alu_en, busy, done, result,
           zero, carry, div_err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequencer that fetches two operands over a shared bus, drives an external ALU
// for one cycle, and registers the result plus status flags.
//
// state | meaning
// IDLE  | waiting for start; op latched on accept
// LDA   | opnd_sel=0, data_in captured into alu_a
// LDB   | opnd_sel=1, data_in captured into alu_b
// EXEC  | ALU enabled; result and flags captured
// WB    | done pulse, then back to IDLE
module alu_seq (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_EXEC, S_WB} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd7;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q, result_q;
  logic       zero_q, carry_q, div_err_q;

  logic [7:0] result_d;
  logic       zero_d, carry_d, div_err_d;
  logic       div0;

  assign div0 = (op_q == OP_DIV) && (b_q == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      result_q  <= 8'h00;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.start) op_q <= bus.op;
      if (state_q == S_LDA) a_q <= bus.data_in;
      if (state_q == S_LDB) b_q <= bus.data_in;
      if (state_q == S_EXEC) begin
        result_q  <= result_d;
        zero_q    <= zero_d;
        carry_q   <= carry_d;
        div_err_q <= div_err_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LDA;
      S_LDA:   state_d = S_LDB;
      S_LDB:   state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flags come from the latched operands; the ALU only supplies the 8-bit value.
  always_comb begin
    result_d  = bus.alu_result;
    carry_d   = 1'b0;
    div_err_d = 1'b0;
    case (op_q)
      OP_ADD: carry_d = (9'(a_q) + 9'(b_q)) > 9'd255;
      OP_SUB: carry_d = a_q < b_q;
      OP_MUL: carry_d = (16'(a_q) * 16'(b_q)) > 16'h00FF;
      OP_DIV: if (div0) begin
        result_d  = 8'hFF;
        div_err_d = 1'b1;
      end
      OP_CMP: begin
        result_d = result_q;
        carry_d  = a_q < b_q;
      end
      default: ;
    endcase
    if (op_q == OP_CMP) zero_d = (a_q == b_q);
    else                zero_d = !div0 && (bus.alu_result == 8'h00);
  end

  always_comb begin
    bus.opnd_sel = (state_q == S_LDB);
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_WB);
    bus.alu_en   = 1'b0;
    bus.alu_opr  = 8'h00;
    if (state_q == S_EXEC && !div0) begin
      bus.alu_en  = 1'b1;
      bus.alu_opr = (op_q == OP_CMP) ? 8'h02 : (8'h01 << op_q);
    end
  end

  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.carry   = carry_q;
  assign bus.div_err = div_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: the bench plays register file and ALU and checks
// each sequence cycle against hand-computed values.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  logic [7:0] reg_a, reg_b;
  logic [7:0] alu_r;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int d0;

  alu_seq_if bus ();

  alu_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.data_in = bus.opnd_sel ? reg_b : reg_a;

  always_comb begin
    alu_r = 8'h00;
    case (bus.alu_opr)
      8'h01: alu_r = bus.alu_a + bus.alu_b;
      8'h02: alu_r = bus.alu_a - bus.alu_b;
      8'h04: alu_r = 8'(16'(bus.alu_a) * 16'(bus.alu_b));
      8'h08: alu_r = (bus.alu_b != 8'h00) ? bus.alu_a / bus.alu_b : 8'h00;
      8'h10: alu_r = bus.alu_a & bus.alu_b;
      8'h20: alu_r = bus.alu_a | bus.alu_b;
      8'h40: alu_r = bus.alu_a ^ bus.alu_b;
      default: alu_r = 8'h00;
    endcase
  end
  assign bus.alu_result = bus.alu_en ? alu_r : 8'h00;

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 3'd0;
    reg_a = 8'h00;
    reg_b = 8'h00;
    #23;
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_outs", {bus.alu_en, bus.opnd_sel, bus.zero, bus.carry, bus.div_err, 11'h0}, 16'h0);
    chk("rst_regs", 16'({bus.alu_a, bus.alu_b, bus.alu_opr, bus.result} != 32'h0), 16'h0);

    // ADD F0+20, start raised together with reset release
    @(negedge clk);
    rst_n = 1'b1;
    reg_a = 8'hF0; reg_b = 8'h20; bus.op = 3'd0; bus.start = 1'b1;
    d0 = done_cnt;
    tick(); bus.start = 1'b0;
    chk("add_lda", {bus.busy, bus.opnd_sel, bus.alu_en, bus.done, 12'h0}, 16'h8000);
    tick();
    chk("add_ldb_sel", 16'(bus.opnd_sel), 16'h1);
    chk("add_alu_a", 16'(bus.alu_a), 16'h00F0);
    chk("add_ldb_en", 16'(bus.alu_en), 16'h0);
    tick();
    chk("add_exec_opr", 16'(bus.alu_opr), 16'h0001);
    chk("add_exec_en", 16'(bus.alu_en), 16'h1);
    chk("add_alu_b", 16'(bus.alu_b), 16'h0020);
    tick();
    chk("add_wb_done", 16'(bus.done), 16'h1);
    chk("add_wb_en", {8'h0, bus.alu_opr}, 16'h0);
    chk("add_result", 16'(bus.result), 16'h0010);
    chk("add_flags", {13'h0, bus.zero, bus.carry, bus.div_err}, 16'h2);
    tick();
    chk("add_idle", {bus.busy, bus.done, 14'h0}, 16'h0);
    chk("add_done_cnt", 16'(done_cnt - d0), 16'h1);

    // CMP 05 vs 05: result must stay at 10
    reg_a = 8'h05; reg_b = 8'h05; bus.op = 3'd7; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick();
    chk("cmp_exec_opr", 16'(bus.alu_opr), 16'h0002);
    tick();
    chk("cmp_done", 16'(bus.done), 16'h1);
    chk("cmp_result", 16'(bus.result), 16'h0010);
    chk("cmp_flags", {13'h0, bus.zero, bus.carry, bus.div_err}, 16'h4);
    tick();

    // DIV 09 / 00
    reg_a = 8'h09; reg_b = 8'h00; bus.op = 3'd3; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick();
    chk("div0_exec_en", {bus.alu_en, 7'h0, bus.alu_opr}, 16'h0);
    chk("div0_busy", 16'(bus.busy), 16'h1);
    tick();
    chk("div0_done", 16'(bus.done), 16'h1);
    chk("div0_result", 16'(bus.result), 16'h00FF);
    chk("div0_flags", {13'h0, bus.zero, bus.carry, bus.div_err}, 16'h1);
    tick();

    // MUL 10*10 overflows to 00
    reg_a = 8'h10; reg_b = 8'h10; bus.op = 3'd2; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick();
    chk("mul_exec_opr", 16'(bus.alu_opr), 16'h0004);
    tick();
    chk("mul_result", 16'(bus.result), 16'h0000);
    chk("mul_flags", {13'h0, bus.zero, bus.carry, bus.div_err}, 16'h6);
    tick();

    // SUB 03-05 with start held high through WB
    reg_a = 8'h03; reg_b = 8'h05; bus.op = 3'd1; bus.start = 1'b1;
    d0 = done_cnt;
    tick(); tick(); tick(); tick();
    chk("hold_wb_done", 16'(bus.done), 16'h1);
    tick();
    chk("hold_idle_gap", 16'(bus.busy), 16'h0);
    tick();
    chk("hold_restart", {bus.busy, bus.opnd_sel, 14'h0}, 16'h8000);
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("hold_result", 16'(bus.result), 16'h00FE);
    chk("hold_flags", {13'h0, bus.zero, bus.carry, bus.div_err}, 16'h2);
    tick(); tick(); tick();
    chk("hold_done_cnt", 16'(done_cnt - d0), 16'h2);

    // Reset pulsed during EXEC of ADD 01+02
    reg_a = 8'h01; reg_b = 8'h02; bus.op = 3'd0; bus.start = 1'b1;
    d0 = done_cnt;
    tick(); bus.start = 1'b0;
    tick(); tick();
    chk("rstx_in_exec", 16'(bus.alu_en), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstx_ctrl", {bus.busy, bus.done, bus.alu_en, bus.opnd_sel, 12'h0}, 16'h0);
    chk("rstx_regs", 16'({bus.alu_a, bus.alu_b, bus.alu_opr, bus.result} != 32'h0), 16'h0);
    chk("rstx_flags", {13'h0, bus.zero, bus.carry, bus.div_err}, 16'h0);
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstx_no_done", 16'(done_cnt - d0), 16'h0);

    // AND 0F & 3C after reset
    reg_a = 8'h0F; reg_b = 8'h3C; bus.op = 3'd4; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick();
    chk("and_exec_opr", 16'(bus.alu_opr), 16'h0010);
    tick();
    chk("and_done", 16'(bus.done), 16'h1);
    chk("and_result", 16'(bus.result), 16'h000C);
    chk("and_flags", {13'h0, bus.zero, bus.carry, bus.div_err}, 16'h0);
    tick();
    chk("and_done_cnt", 16'(done_cnt - d0), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
